// File: rtl/regfile_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sched_pkg
// Brief    : Shared types and constants for the register-file write scheduler
// Revision : 1.0 - initial release
// ============================================================================
package regfile_sched_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } sched_state_t;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } io_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rf_wq_fifo
// Brief    : Synchronous FIFO holding pending IO register writes, with flush
// Revision : 1.0 - initial release
// ============================================================================
module rf_wq_fifo
    import regfile_sched_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  io_entry_t push_data,
    input  logic      pop,
    output io_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(QDEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    io_entry_t   r_mem [QDEPTH];

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign head  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push && !full)
                r_wptr <= r_wptr + 1'b1;
            if (pop && !empty)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            r_mem[r_wptr[PW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_sched
// Brief    : Arbitrates the register-file write port among CPU, IO queue and
//            the r1..r31 clear sequencer
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_sched
    import regfile_sched_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_waddr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    input  logic          io_valid,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_data,
    output logic          io_ready,
    input  logic          io_en,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    sched_state_t  r_state;
    logic [WW-1:0] r_wait_cnt;
    logic [AW-1:0] r_idx;

    io_entry_t w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_run;
    logic      w_forced;
    logic      w_cpu_ok;
    logic      w_cpu_grant;
    logic      w_io_grant;
    logic      w_push;
    logic      w_flush;

    assign w_run       = (r_state == ST_RUN);
    assign w_forced    = w_run && !w_empty && io_en && (r_wait_cnt == WW'(MAX_WAIT));
    assign w_cpu_ok    = cpu_we && (cpu_waddr != REG_ZERO);
    assign w_cpu_grant = w_run && !w_forced && w_cpu_ok;
    assign w_io_grant  = w_forced || (w_run && !w_cpu_ok && !w_empty && io_en);

    assign cpu_stall = w_run ? (cpu_we && w_forced) : cpu_we;
    assign io_ready  = !w_full && !clr_busy;
    // Writes to r0 are accepted from the producer but never stored.
    assign w_push    = io_valid && io_ready && (io_addr != REG_ZERO);
    assign w_flush   = w_run && clr_req;

    rf_wq_fifo #(
        .QDEPTH (QDEPTH)
    ) u_wq (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_flush),
        .push      (w_push),
        .push_data ('{addr: io_addr, data: io_data}),
        .pop       (w_io_grant),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_idx      <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    rf_we    <= w_cpu_grant || w_io_grant;
                    rf_waddr <= w_io_grant ? w_head.addr : (w_cpu_grant ? cpu_waddr : REG_ZERO);
                    rf_wdata <= w_io_grant ? w_head.data : (w_cpu_grant ? cpu_wdata : '0);
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        r_state    <= ST_CLEAR;
                        r_idx      <= AW'(1);
                        r_wait_cnt <= '0;
                        clr_busy   <= 1'b1;
                    end else if (w_io_grant || w_empty) begin
                        r_wait_cnt <= '0;
                    end else if (io_en && (r_wait_cnt != WW'(MAX_WAIT))) begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    end
                end
                ST_CLEAR: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= r_idx;
                    rf_wdata <= '0;
                    clr_done <= (r_idx == AW'(NREG - 1));
                    r_idx    <= r_idx + AW'(1);
                    if (r_idx == AW'(NREG - 1)) begin
                        r_state  <= ST_RUN;
                        clr_busy <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire
